// File: rtl/instr_cache_ctrl.sv
// rtl/instr_cache_ctrl.sv - direct-mapped instruction cache with single-block refill FSM
module instr_cache_ctrl #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_read,
    input  logic [31:0]  cpu_address,
    output logic [31:0]  cpu_readdata,
    output logic         cpu_busywait,
    input  logic         flush,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t r_state, w_next_state;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [127:0]        r_data [LINES];
    logic [27:0]         r_mem_address;
    logic                r_flush_pend;

    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic                  w_miss;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;

    assign w_offset     = cpu_address[3:2];
    assign w_index      = cpu_address[4 +: INDEX_BITS];
    assign w_tag        = cpu_address[31 -: TAG_BITS];
    assign w_hit        = cpu_read & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_miss       = cpu_read & ~w_hit;
    assign w_fill_index = r_mem_address[INDEX_BITS-1:0];
    assign w_fill_tag   = r_mem_address[27 -: TAG_BITS];

    assign cpu_readdata = r_data[w_index][{w_offset, 5'b0} +: 32];
    assign cpu_busywait = w_miss | (r_state != IDLE);
    assign mem_address  = r_mem_address;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_read     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_miss && !flush) begin
                    w_next_state = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    w_next_state = UPDATE;
                end
            end
            UPDATE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A flush seen mid-refill wins over the install, so the new line also ends up invalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid       <= '0;
            r_flush_pend  <= 1'b0;
            r_mem_address <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (w_miss) begin
                        r_mem_address <= {w_tag, w_index};
                    end
                end
                MEM_READ: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                UPDATE: begin
                    if (r_flush_pend || flush) begin
                        r_valid <= '0;
                    end else begin
                        r_valid[w_fill_index] <= 1'b1;
                    end
                    r_flush_pend <= 1'b0;
                end
                default: begin
                    r_flush_pend <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && r_state == UPDATE) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= mem_readdata;
        end
    end
endmodule

// File: tb/tb_instr_cache_ctrl.sv
// tb/tb_instr_cache_ctrl.sv - self-checking bench for instr_cache_ctrl against a line-table reference model
module tb_instr_cache_ctrl;
    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic [31:0]  cpu_address;
    logic [31:0]  cpu_readdata;
    logic         cpu_busywait;
    logic         flush;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_m   = 0;
    int mcnt    = 0;

    bit          ref_valid [8];
    logic [24:0] ref_tag   [8];

    always #5 clock = ~clock;

    instr_cache_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_read     (cpu_read),
        .cpu_address  (cpu_address),
        .cpu_readdata (cpu_readdata),
        .cpu_busywait (cpu_busywait),
        .flush        (flush),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
        if (blk == 28'h0) begin
            case (w)
                2'd0:    return 32'h00A0_0093;
                2'd1:    return 32'h0050_6113;
                default: return 32'h0000_0013;
            endcase
        end
        return ({4'h0, blk} * 32'h0100_0193) ^ {w, 30'h0} ^ 32'h5A5A_0F0F;
    endfunction

    always_comb begin
        mem_readdata = '0;
        for (int i = 0; i < 4; i++) begin
            mem_readdata[32*i +: 32] = mem_word(mem_address, i[1:0]);
        end
    end

    // Memory holds busywait high for the first cur_m posedges of each read request.
    always @(posedge clock) begin
        if (mem_read) mcnt <= mcnt + 1;
        else          mcnt <= 0;
    end
    assign mem_busywait = mem_read && (mcnt < cur_m);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic flush_model();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input int m, input int flush_cyc);
        logic [2:0]  idx;
        logic [24:0] tg;
        bit          hit;
        bit          fl_mid;
        int          exp_stall;
        int          exp_rises;
        int          cyc;
        int          rises;
        logic        prev_mr;
        idx       = pc[6:4];
        tg        = pc[31:7];
        hit       = ref_valid[idx] && (ref_tag[idx] == tg);
        fl_mid    = !hit && flush_cyc >= 1 && flush_cyc <= m + 2;
        exp_stall = hit ? 0 : (fl_mid ? 2*m + 6 : m + 3);
        exp_rises = hit ? 0 : (fl_mid ? 2 : 1);
        cyc       = 0;
        rises     = 0;
        cur_m     = m;
        @(negedge clock);
        cpu_read    = 1'b1;
        cpu_address = pc;
        flush       = 1'b0;
        #1;
        prev_mr = mem_read;
        if (hit) chk("hit_no_mem_read", {31'b0, mem_read}, 32'd0);
        while (cpu_busywait && cyc < 200) begin
            if (!hit && cyc >= 1 && cyc <= m + 1) begin
                chk("mem_read_high", {31'b0, mem_read}, 32'd1);
                chk("mem_address", {4'h0, mem_address}, {4'h0, pc[31:4]});
            end
            if (!hit && cyc == m + 2) chk("mem_read_in_update", {31'b0, mem_read}, 32'd0);
            @(negedge clock);
            cyc++;
            flush = (cyc == flush_cyc);
            #1;
            if (mem_read && !prev_mr) rises++;
            prev_mr = mem_read;
        end
        flush = 1'b0;
        chk("stall_cycles", cyc, exp_stall);
        chk("mem_read_rises", rises, exp_rises);
        chk("busywait_done", {31'b0, cpu_busywait}, 32'd0);
        chk("readdata", cpu_readdata, mem_word(pc[31:4], pc[3:2]));
        if (!hit) begin
            if (fl_mid) flush_model();
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
    endtask

    initial begin
        logic [31:0] pc;
        reset       = 1'b1;
        cpu_read    = 1'b0;
        cpu_address = 32'h0;
        flush       = 1'b0;
        flush_model();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_address", {4'h0, mem_address}, 32'd0);
        chk("rst_busywait", {31'b0, cpu_busywait}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        fetch(32'h0000_0000, 2, -1);
        fetch(32'h0000_0004, 0, -1);
        fetch(32'h0000_0008, 0, -1);
        fetch(32'h0000_000C, 0, -1);
        fetch(32'h0000_0080, 1, -1);
        fetch(32'h0000_0000, 1, -1);

        fetch(32'h0000_0010, 1, -1);
        fetch(32'h0000_0024, 4, -1);
        fetch(32'h0000_0038, 16, -1);

        @(negedge clock);
        cpu_read    = 1'b1;
        cpu_address = 32'h0000_0004;
        flush       = 1'b1;
        #1;
        chk("flush_idle_hit_before", {31'b0, cpu_busywait}, 32'd0);
        @(negedge clock);
        flush    = 1'b0;
        cpu_read = 1'b0;
        flush_model();
        #1;
        chk("flush_idle_no_refill", {31'b0, mem_read}, 32'd0);
        fetch(32'h0000_0004, 2, -1);

        @(negedge clock);
        cpu_read    = 1'b1;
        cpu_address = 32'h0000_0040;
        flush       = 1'b1;
        @(negedge clock);
        flush    = 1'b0;
        cpu_read = 1'b0;
        flush_model();
        #1;
        chk("flush_blocks_miss", {31'b0, mem_read}, 32'd0);

        fetch(32'h0000_0200, 3, 2);

        cur_m = 6;
        @(negedge clock);
        cpu_read    = 1'b1;
        cpu_address = 32'h0000_0100;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("pre_reset_mem_read", {31'b0, mem_read}, 32'd1);
        @(negedge clock);
        reset    = 1'b0;
        cpu_read = 1'b0;
        #1;
        chk("reset_abort_mem_read", {31'b0, mem_read}, 32'd0);
        chk("reset_abort_idle", {31'b0, cpu_busywait}, 32'd0);
        chk("reset_abort_addr", {4'h0, mem_address}, 32'd0);
        flush_model();
        fetch(32'h0000_0100, 2, -1);

        for (int n = 0; n < 60; n++) begin
            pc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4)
               | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) pc = pc | ($urandom & 32'hFFFF_FF80);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clock);
                cpu_read = 1'b0;
                flush    = 1'b1;
                @(negedge clock);
                flush = 1'b0;
                flush_model();
            end
            fetch(pc, $urandom_range(0, 5), -1);
        end

        @(negedge clock);
        cpu_read = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
